// File: rtl/gcd_arbiter.sv
// Round-robin arbiter that serialises NReq requesters onto one shared GCD engine.
// Sequences each job through LOAD/RUN/DONE, with a RUN watchdog that aborts and resets the engine.
module gcd_arbiter #(
  parameter int NBits = 16,
  parameter int NReq  = 4,
  parameter int TMO   = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NReq-1:0]         req,
  input  logic [NReq*NBits-1:0]   xi_bus,
  input  logic [NReq*NBits-1:0]   yi_bus,
  output logic [NReq-1:0]         gnt,
  output logic                    res_valid,
  output logic                    res_err,
  output logic [NBits-1:0]        res_data,
  output logic                    busy,
  output logic [NBits-1:0]        eng_xi,
  output logic [NBits-1:0]        eng_yi,
  output logic                    eng_start,
  output logic                    eng_rst,
  input  logic [NBits-1:0]        eng_xo,
  input  logic                    eng_rdy
);

  localparam int LW = (NReq > 1) ? $clog2(NReq) : 1;
  localparam int CW = (TMO > 1) ? $clog2(TMO) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DONE, ABORT} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [NReq-1:0]   r_gnt;
  logic [LW-1:0]     r_last;
  logic [NBits-1:0]  r_x;
  logic [NBits-1:0]  r_y;
  logic [NBits-1:0]  r_res_data;
  logic [CW-1:0]     r_cnt;

  logic              w_found;
  logic [LW-1:0]     w_sel;
  logic [NReq-1:0]   w_sel_oh;
  logic              w_timeout;

  // Search starts one past the last winner; the final iteration wraps back onto it.
  always_comb begin
    int idx;
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_found = 1'b0;
    w_sel   = '0;
    idx     = 0;
    for (int i = 1; i <= NReq; i++) begin
      idx = int'(r_last) + i;
      if (idx >= NReq) idx = idx - NReq;
      if (!w_found && req[idx]) begin
        w_found = 1'b1;
        w_sel   = LW'(idx);
      end
    end
  end

  assign w_sel_oh  = NReq'(1) << w_sel;
  assign w_timeout = (r_cnt == CW'(TMO - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_found) w_next = LOAD;
      LOAD:    w_next = RUN;
      RUN: begin
        if (eng_rdy)        w_next = DONE;
        else if (w_timeout) w_next = ABORT;
      end
      DONE:    w_next = IDLE;
      ABORT:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments; reset is synchronous, so it only acts on a clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_gnt      <= '0;
      r_last     <= LW'(NReq - 1);
      r_x        <= '0;
      r_y        <= '0;
      r_res_data <= '0;
      r_cnt      <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_gnt  <= w_sel_oh;
            r_last <= w_sel;
            r_x    <= xi_bus[w_sel*NBits +: NBits];
            r_y    <= yi_bus[w_sel*NBits +: NBits];
          end
        end
        LOAD: r_cnt <= '0;
        RUN: begin
          if (eng_rdy)        r_res_data <= eng_xo;
          else if (w_timeout) r_res_data <= '0;
          else                r_cnt      <= r_cnt + CW'(1);
        end
        DONE, ABORT: r_gnt <= '0;
        default: r_gnt <= '0;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign res_valid = (r_state == DONE) || (r_state == ABORT);
  assign res_err   = (r_state == ABORT);
  assign res_data  = r_res_data;
  assign busy      = (r_state != IDLE);
  assign eng_xi    = r_x;
  assign eng_yi    = r_y;
  assign eng_start = (r_state == RUN);
  assign eng_rst   = rst | (r_state == ABORT);

endmodule

// File: tb/tb_gcd_arbiter.sv
// Directed bench for gcd_arbiter with a behavioural subtractive GCD engine.
module tb_gcd_arbiter;

  localparam int NB = 16;
  localparam int NR = 4;
  localparam int WAIT_LIM = 200;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NR-1:0]  req = '0;
  logic [NR*NB-1:0] xi_bus = '0;
  logic [NR*NB-1:0] yi_bus = '0;
  logic [NR-1:0]  gnt;
  logic           res_valid, res_err, busy, eng_start, eng_rst, eng_rdy;
  logic [NB-1:0]  res_data, eng_xi, eng_yi, eng_xo;
  logic           stall = 1'b0;
  logic [NB-1:0]  ex, ey;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gcd_arbiter #(.NBits(NB), .NReq(NR), .TMO(16)) dut (
    .clk(clk), .rst(rst), .req(req), .xi_bus(xi_bus), .yi_bus(yi_bus),
    .gnt(gnt), .res_valid(res_valid), .res_err(res_err), .res_data(res_data),
    .busy(busy), .eng_xi(eng_xi), .eng_yi(eng_yi), .eng_start(eng_start),
    .eng_rst(eng_rst), .eng_xo(eng_xo), .eng_rdy(eng_rdy)
  );

  // Behavioural engine: loads while eng_start=0, subtracts while eng_start=1.
  always @(posedge clk) begin
    if (eng_rst) begin
      ex <= '0; ey <= '0;
    end else if (!eng_start) begin
      ex <= eng_xi; ey <= eng_yi;
    end else if (ex > ey) ex <= ex - ey;
    else if (ey > ex)     ey <= ey - ex;
  end
  assign eng_xo  = ex;
  assign eng_rdy = eng_start && (ex == ey) && !stall;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int k, input logic [NB-1:0] x, input logic [NB-1:0] y);
    xi_bus[k*NB +: NB] = x;
    yi_bus[k*NB +: NB] = y;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (res_valid !== 1'b1 && n < WAIT_LIM) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    set_op(0, 16'd7, 16'd9);
    do_reset();
    rst = 1'b1;
    #1;
    total++; if (eng_rst !== 1'b1) begin bad++; $display("FAIL rst_eng_rst got=%b exp=1", eng_rst); end
    rst = 1'b0;
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL rst_gnt got=%b exp=0000", gnt); end
    total++; if (res_valid !== 1'b0 || res_err !== 1'b0) begin bad++; $display("FAIL rst_res got=%b%b exp=00", res_valid, res_err); end
    total++; if (res_data !== 16'd0) begin bad++; $display("FAIL rst_res_data got=%0d exp=0", res_data); end
    total++; if (busy !== 1'b0 || eng_start !== 1'b0) begin bad++; $display("FAIL rst_busy_start got=%b%b exp=00", busy, eng_start); end
    total++; if (eng_xi !== 16'd0 || eng_yi !== 16'd0) begin bad++; $display("FAIL rst_operands got=%0d/%0d exp=0/0", eng_xi, eng_yi); end
  endtask

  task automatic test_single();
    int n;
    set_op(0, 16'd12, 16'd18);
    req = 4'b0001;
    step();
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL single_gnt got=%b exp=0001", gnt); end
    total++; if (busy !== 1'b1 || eng_start !== 1'b0) begin bad++; $display("FAIL single_load got busy/start=%b%b exp=10", busy, eng_start); end
    total++; if (eng_xi !== 16'd12 || eng_yi !== 16'd18) begin bad++; $display("FAIL single_operands got=%0d/%0d exp=12/18", eng_xi, eng_yi); end
    req = '0;
    step();
    total++; if (eng_start !== 1'b1) begin bad++; $display("FAIL single_run got=%b exp=1", eng_start); end
    wait_valid(n);
    total++; if (n !== 3) begin bad++; $display("FAIL single_latency got=%0d exp=3", n); end
    total++; if (res_data !== 16'd6 || res_err !== 1'b0) begin bad++; $display("FAIL single_result got=%0d err=%b exp=6 err=0", res_data, res_err); end
    step();
    total++; if (busy !== 1'b0 || gnt !== 4'b0000 || res_valid !== 1'b0) begin bad++; $display("FAIL single_idle got busy=%b gnt=%b valid=%b exp 0/0000/0", busy, gnt, res_valid); end
  endtask

  task automatic test_back_to_back();
    int n;
    do_reset();
    set_op(0, 16'd8, 16'd12);
    set_op(1, 16'd9, 16'd6);
    req = 4'b0011;
    step();
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL b2b_first_gnt got=%b exp=0001", gnt); end
    wait_valid(n);
    total++; if (n !== 4 || res_data !== 16'd4) begin bad++; $display("FAIL b2b_first_result got n=%0d data=%0d exp n=4 data=4", n, res_data); end
    step();
    total++; if (gnt !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL b2b_gap got gnt=%b busy=%b exp 0000/0", gnt, busy); end
    step();
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL b2b_second_gnt got=%b exp=0010", gnt); end
    wait_valid(n);
    total++; if (n !== 4 || res_data !== 16'd3) begin bad++; $display("FAIL b2b_second_result got n=%0d data=%0d exp n=4 data=3", n, res_data); end
    req = '0;
    step();
  endtask

  task automatic test_fairness();
    int n;
    logic [NR-1:0] exp_g;
    do_reset();
    for (int k = 0; k < NR; k++) set_op(k, NB'(k + 1), NB'(k + 1));
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      exp_g = NR'(1) << (g % NR);
      step();
      total++; if (gnt !== exp_g) begin bad++; $display("FAIL fair_gnt%0d got=%b exp=%b", g, gnt, exp_g); end
      wait_valid(n);
      total++; if (n !== 2 || res_data !== NB'((g % NR) + 1)) begin bad++; $display("FAIL fair_result%0d got n=%0d data=%0d exp n=2 data=%0d", g, n, res_data, (g % NR) + 1); end
      if (g == 4) req = '0;
      step();
      total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL fair_gap%0d got=%b exp=0000", g, gnt); end
    end
  endtask

  task automatic test_timeout();
    int n;
    set_op(2, 16'd5, 16'd10);
    stall = 1'b1;
    req = 4'b0100;
    step();
    total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL tmo_gnt got=%b exp=0100", gnt); end
    req = '0;
    n = 0;
    step();
    while (eng_start === 1'b1 && n < 100) begin
      n++;
      step();
    end
    total++; if (n !== 16) begin bad++; $display("FAIL tmo_run_cycles got=%0d exp=16", n); end
    total++; if (eng_rst !== 1'b1 || res_valid !== 1'b1 || res_err !== 1'b1) begin bad++; $display("FAIL tmo_abort got rst/valid/err=%b%b%b exp=111", eng_rst, res_valid, res_err); end
    total++; if (res_data !== 16'd0 || gnt !== 4'b0100) begin bad++; $display("FAIL tmo_abort_data got data=%0d gnt=%b exp 0/0100", res_data, gnt); end
    stall = 1'b0;
    set_op(1, 16'd9, 16'd6);
    req = 4'b0010;
    step();
    total++; if (eng_rst !== 1'b0 || gnt !== 4'b0000 || res_valid !== 1'b0) begin bad++; $display("FAIL tmo_idle got rst=%b gnt=%b valid=%b exp 0/0000/0", eng_rst, gnt, res_valid); end
    step();
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL tmo_next_gnt got=%b exp=0010", gnt); end
    req = '0;
    wait_valid(n);
    total++; if (n !== 4 || res_data !== 16'd3 || res_err !== 1'b0) begin bad++; $display("FAIL tmo_next_result got n=%0d data=%0d err=%b exp 4/3/0", n, res_data, res_err); end
    step();
  endtask

  task automatic test_reset_mid_run();
    int n;
    set_op(1, 16'd100, 16'd1);
    set_op(0, 16'd12, 16'd18);
    set_op(2, 16'd7, 16'd7);
    req = 4'b0010;
    step();
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL midrst_gnt got=%b exp=0010", gnt); end
    req = '0;
    step(); step(); step();
    total++; if (eng_start !== 1'b1) begin bad++; $display("FAIL midrst_in_run got=%b exp=1", eng_start); end
    rst = 1'b1;
    req = 4'b0101;
    #1;
    total++; if (eng_rst !== 1'b1) begin bad++; $display("FAIL midrst_eng_rst got=%b exp=1", eng_rst); end
    step();
    total++; if (gnt !== 4'b0000 || busy !== 1'b0 || res_valid !== 1'b0 || eng_start !== 1'b0) begin bad++; $display("FAIL midrst_outputs got gnt=%b busy=%b valid=%b start=%b exp all 0", gnt, busy, res_valid, eng_start); end
    total++; if (res_data !== 16'd0 || eng_xi !== 16'd0 || eng_yi !== 16'd0) begin bad++; $display("FAIL midrst_data got data=%0d xi=%0d yi=%0d exp 0/0/0", res_data, eng_xi, eng_yi); end
    rst = 1'b0;
    step();
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL midrst_first_gnt got=%b exp=0001", gnt); end
    wait_valid(n);
    total++; if (n !== 4 || res_data !== 16'd6) begin bad++; $display("FAIL midrst_first_result got n=%0d data=%0d exp 4/6", n, res_data); end
    step(); step();
    total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL midrst_second_gnt got=%b exp=0100", gnt); end
    req = '0;
    wait_valid(n);
    total++; if (n !== 2 || res_data !== 16'd7) begin bad++; $display("FAIL midrst_second_result got n=%0d data=%0d exp 2/7", n, res_data); end
    step();
  endtask

  task automatic test_operand_change();
    int n;
    set_op(0, 16'd20, 16'd15);
    req = 4'b0001;
    step();
    total++; if (gnt !== 4'b0001 || eng_xi !== 16'd20) begin bad++; $display("FAIL opchg_load got gnt=%b xi=%0d exp 0001/20", gnt, eng_xi); end
    req = '0;
    set_op(0, 16'd99, 16'd33);
    step();
    total++; if (eng_xi !== 16'd20 || eng_yi !== 16'd15) begin bad++; $display("FAIL opchg_hold got=%0d/%0d exp=20/15", eng_xi, eng_yi); end
    wait_valid(n);
    total++; if (n !== 4 || res_data !== 16'd5 || res_err !== 1'b0) begin bad++; $display("FAIL opchg_result got n=%0d data=%0d err=%b exp 4/5/0", n, res_data, res_err); end
    total++; if (gnt !== 4'b0001 || eng_xi !== 16'd20) begin bad++; $display("FAIL opchg_done got gnt=%b xi=%0d exp 0001/20", gnt, eng_xi); end
    step();
    total++; if (busy !== 1'b0 || gnt !== 4'b0000) begin bad++; $display("FAIL opchg_idle got busy=%b gnt=%b exp 0/0000", busy, gnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fairness();
    test_timeout();
    test_reset_mid_run();
    test_operand_change();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
